// File: rtl/multi_countdown_timer_if.sv
// rtl/multi_countdown_timer_if.sv - button/display bundle for the multi-channel countdown timer
interface multi_countdown_timer_if #(
    parameter int NUM_CH = 4
) ();
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              en;
    logic [CW-1:0]     ch_sel;
    logic              inc;
    logic              dec;
    logic              state;
    logic              start;
    logic              rld;
    logic [5:0]        hours;
    logic [5:0]        minutes;
    logic [5:0]        seconds;
    logic [6:0]        centis;
    logic [1:0]        mode;
    logic [1:0]        run;
    logic              reload;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] expire_pulse;
    logic              any_done;

    modport master (
        output en, ch_sel, inc, dec, state, start, rld,
        input  hours, minutes, seconds, centis, mode, run, reload, done, expire_pulse, any_done
    );

    modport slave (
        input  en, ch_sel, inc, dec, state, start, rld,
        output hours, minutes, seconds, centis, mode, run, reload, done, expire_pulse, any_done
    );
endinterface

// File: rtl/multi_countdown_timer.sv
// rtl/multi_countdown_timer.sv - NUM_CH hh:mm:ss.cc countdown timers sharing one prescaler and button set
module multi_countdown_timer #(
    parameter int NUM_CH   = 4,
    parameter int TICK_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    multi_countdown_timer_if.slave bus
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {M_HOURS = 2'd0, M_MINUTES = 2'd1, M_SECONDS = 2'd2, M_CLOCK = 2'd3} mode_t;
    typedef enum logic [1:0] {R_STOPPED = 2'd0, R_RUNNING = 2'd1, R_EXPIRED = 2'd2} run_t;

    logic [PW-1:0]     pre_cnt;
    logic              tick;

    logic [5:0]        h_q  [NUM_CH];
    logic [5:0]        m_q  [NUM_CH];
    logic [5:0]        s_q  [NUM_CH];
    logic [6:0]        c_q  [NUM_CH];
    logic [5:0]        ph_q [NUM_CH];
    logic [5:0]        pm_q [NUM_CH];
    logic [5:0]        ps_q [NUM_CH];
    mode_t             mode_q [NUM_CH];
    run_t              run_q  [NUM_CH];
    logic [NUM_CH-1:0] rld_q;
    logic [NUM_CH-1:0] done_q;
    logic [NUM_CH-1:0] pulse_q;

    logic [NUM_CH-1:0] sel_vec;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] is_zero;
    logic [NUM_CH-1:0] hits_zero;
    logic [5:0]        dh [NUM_CH];
    logic [5:0]        dm [NUM_CH];
    logic [5:0]        ds [NUM_CH];
    logic [6:0]        dc [NUM_CH];
    logic [5:0]        eh [NUM_CH];
    logic [5:0]        em [NUM_CH];
    logic [5:0]        es [NUM_CH];

    logic b_state, b_start, b_inc, b_dec;

    assign b_state = bus.state;
    assign b_start = bus.start & ~bus.state;
    assign b_inc   = bus.inc & ~bus.state & ~bus.start;
    assign b_dec   = bus.dec & ~bus.state & ~bus.start & ~bus.inc;

    assign tick = (pre_cnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    // Per-channel decode, borrow-chain decrement and field edit values
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sel_vec[i]   = (bus.ch_sel == CW'(i));
            hit[i]       = bus.en & sel_vec[i];
            is_zero[i]   = (h_q[i] == 6'd0) && (m_q[i] == 6'd0) && (s_q[i] == 6'd0) && (c_q[i] == 7'd0);
            hits_zero[i] = (h_q[i] == 6'd0) && (m_q[i] == 6'd0) && (s_q[i] == 6'd0) && (c_q[i] == 7'd1);

            dc[i] = (c_q[i] == 7'd0) ? 7'd99 : c_q[i] - 7'd1;
            ds[i] = s_q[i];
            dm[i] = m_q[i];
            dh[i] = h_q[i];
            if (c_q[i] == 7'd0) begin
                ds[i] = (s_q[i] == 6'd0) ? 6'd59 : s_q[i] - 6'd1;
                if (s_q[i] == 6'd0) begin
                    dm[i] = (m_q[i] == 6'd0) ? 6'd59 : m_q[i] - 6'd1;
                    if (m_q[i] == 6'd0)
                        dh[i] = (h_q[i] == 6'd0) ? 6'd23 : h_q[i] - 6'd1;
                end
            end

            eh[i] = h_q[i];
            em[i] = m_q[i];
            es[i] = s_q[i];
            case (mode_q[i])
                M_HOURS:   eh[i] = b_inc ? ((h_q[i] == 6'd23) ? 6'd0 : h_q[i] + 6'd1)
                                         : ((h_q[i] == 6'd0) ? 6'd23 : h_q[i] - 6'd1);
                M_MINUTES: em[i] = b_inc ? ((m_q[i] == 6'd59) ? 6'd0 : m_q[i] + 6'd1)
                                         : ((m_q[i] == 6'd0) ? 6'd59 : m_q[i] - 6'd1);
                M_SECONDS: es[i] = b_inc ? ((s_q[i] == 6'd59) ? 6'd0 : s_q[i] + 6'd1)
                                         : ((s_q[i] == 6'd0) ? 6'd59 : s_q[i] - 6'd1);
                default: ;
            endcase
        end
    end

    // Button actions first; a same-cycle expiry below overrides them on done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                h_q[i]    <= '0;
                m_q[i]    <= '0;
                s_q[i]    <= '0;
                c_q[i]    <= '0;
                ph_q[i]   <= '0;
                pm_q[i]   <= '0;
                ps_q[i]   <= '0;
                mode_q[i] <= M_HOURS;
                run_q[i]  <= R_STOPPED;
            end
            rld_q   <= '0;
            done_q  <= '0;
            pulse_q <= '0;
        end else begin
            pulse_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit[i]) begin
                    if (b_state) begin
                        case (run_q[i])
                            R_STOPPED: mode_q[i] <= mode_t'(mode_q[i] + 2'd1);
                            R_EXPIRED: begin
                                run_q[i]  <= R_STOPPED;
                                mode_q[i] <= M_HOURS;
                                done_q[i] <= 1'b0;
                                h_q[i]    <= ph_q[i];
                                m_q[i]    <= pm_q[i];
                                s_q[i]    <= ps_q[i];
                                c_q[i]    <= '0;
                            end
                            default:   done_q[i] <= 1'b0;
                        endcase
                    end else if (b_start && mode_q[i] == M_CLOCK) begin
                        if (run_q[i] == R_STOPPED) begin
                            if (is_zero[i]) begin
                                run_q[i]   <= R_EXPIRED;
                                done_q[i]  <= 1'b1;
                                pulse_q[i] <= 1'b1;
                            end else begin
                                run_q[i]   <= R_RUNNING;
                            end
                        end else if (run_q[i] == R_RUNNING) begin
                            run_q[i] <= R_STOPPED;
                        end
                    end else if ((b_inc || b_dec) && run_q[i] == R_STOPPED && mode_q[i] != M_CLOCK) begin
                        h_q[i]    <= eh[i];
                        m_q[i]    <= em[i];
                        s_q[i]    <= es[i];
                        ph_q[i]   <= eh[i];
                        pm_q[i]   <= em[i];
                        ps_q[i]   <= es[i];
                        c_q[i]    <= '0;
                        done_q[i] <= 1'b0;
                    end
                end

                if (hit[i] && bus.rld && run_q[i] == R_STOPPED)
                    rld_q[i] <= ~rld_q[i];

                if (run_q[i] == R_RUNNING && tick && !(hit[i] && b_start && mode_q[i] == M_CLOCK)) begin
                    if (hits_zero[i]) begin
                        done_q[i]  <= 1'b1;
                        pulse_q[i] <= 1'b1;
                        c_q[i]     <= '0;
                        if (rld_q[i]) begin
                            h_q[i] <= ph_q[i];
                            m_q[i] <= pm_q[i];
                            s_q[i] <= ps_q[i];
                        end else begin
                            run_q[i] <= R_EXPIRED;
                            h_q[i]   <= '0;
                            m_q[i]   <= '0;
                            s_q[i]   <= '0;
                        end
                    end else begin
                        h_q[i] <= dh[i];
                        m_q[i] <= dm[i];
                        s_q[i] <= ds[i];
                        c_q[i] <= dc[i];
                    end
                end
            end
        end
    end

    // Out-of-range ch_sel matches no channel, so the display reads all zero
    always_comb begin
        bus.hours   = '0;
        bus.minutes = '0;
        bus.seconds = '0;
        bus.centis  = '0;
        bus.mode    = '0;
        bus.run     = '0;
        bus.reload  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_vec[i]) begin
                bus.hours   = h_q[i];
                bus.minutes = m_q[i];
                bus.seconds = s_q[i];
                bus.centis  = c_q[i];
                bus.mode    = mode_q[i];
                bus.run     = run_q[i];
                bus.reload  = rld_q[i];
            end
        end
    end

    assign bus.done         = done_q;
    assign bus.expire_pulse = pulse_q;
    assign bus.any_done     = |done_q;
endmodule

// File: tb/tb_multi_countdown_timer.sv
// tb/tb_multi_countdown_timer.sv - bench for multi_countdown_timer (TICK_DIV=1 x4 ch, TICK_DIV=4 x3 ch)
module tb_multi_countdown_timer;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    multi_countdown_timer_if #(.NUM_CH(4)) ia ();
    multi_countdown_timer_if #(.NUM_CH(3)) ib ();

    multi_countdown_timer #(.NUM_CH(4), .TICK_DIV(1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ia));
    multi_countdown_timer #(.NUM_CH(3), .TICK_DIV(4)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ib));

    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_RLD   = 5'b00001;
    localparam logic [4:0] B_DEC   = 5'b00010;
    localparam logic [4:0] B_INC   = 5'b00100;
    localparam logic [4:0] B_START = 5'b01000;
    localparam logic [4:0] B_STATE = 5'b10000;

    typedef struct {
        logic       en;
        logic [1:0] sel;
        logic [4:0] btn;
        int         h, m, s, c, md, rn, rl;
    } vec_t;
    vec_t tbl [21];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int npulse, first_k, last_k, ndec, c0, c3, v, vn, e, r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge; pulses for one posedge, returns at the next negedge
    task automatic step_a(input logic e_in, input logic [1:0] sel, input logic [4:0] b);
        ia.en = e_in;
        ia.ch_sel = sel;
        {ia.state, ia.start, ia.inc, ia.dec, ia.rld} = b;
        @(negedge clk);
        {ia.state, ia.start, ia.inc, ia.dec, ia.rld} = '0;
    endtask

    task automatic step_b(input logic e_in, input logic [1:0] sel, input logic [4:0] b);
        ib.en = e_in;
        ib.ch_sel = sel;
        {ib.state, ib.start, ib.inc, ib.dec, ib.rld} = b;
        @(negedge clk);
        {ib.state, ib.start, ib.inc, ib.dec, ib.rld} = '0;
    endtask

    task automatic chk_disp_a(input string nm, input int h, input int m, input int s, input int c,
                              input int md, input int rn, input int rl);
        chk({nm, ".h"},  ia.hours,   h);
        chk({nm, ".m"},  ia.minutes, m);
        chk({nm, ".s"},  ia.seconds, s);
        chk({nm, ".c"},  ia.centis,  c);
        chk({nm, ".md"}, ia.mode,    md);
        chk({nm, ".rn"}, ia.run,     rn);
        chk({nm, ".rl"}, ia.reload,  rl);
    endtask

    initial begin
        // editing sequence on A channel 2, starting from reset
        tbl[0]  = '{1'b1, 2'd2, B_NONE,          0,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1'b1, 2'd2, B_DEC,          23,  0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1'b1, 2'd2, B_INC,           0,  0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1'b1, 2'd2, B_INC,           1,  0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1'b1, 2'd2, B_STATE,         1,  0, 0, 0, 1, 0, 0};
        tbl[5]  = '{1'b1, 2'd2, B_DEC,           1, 59, 0, 0, 1, 0, 0};
        tbl[6]  = '{1'b1, 2'd2, B_INC,           1,  0, 0, 0, 1, 0, 0};
        tbl[7]  = '{1'b1, 2'd2, B_DEC,           1, 59, 0, 0, 1, 0, 0};
        tbl[8]  = '{1'b1, 2'd2, B_STATE | B_INC, 1, 59, 0, 0, 2, 0, 0};
        tbl[9]  = '{1'b1, 2'd2, B_INC,           1, 59, 1, 0, 2, 0, 0};
        tbl[10] = '{1'b0, 2'd2, B_INC,           1, 59, 1, 0, 2, 0, 0};
        tbl[11] = '{1'b1, 2'd2, B_RLD,           1, 59, 1, 0, 2, 0, 1};
        tbl[12] = '{1'b1, 2'd2, B_RLD | B_INC,   1, 59, 2, 0, 2, 0, 0};
        tbl[13] = '{1'b1, 2'd2, B_STATE,         1, 59, 2, 0, 3, 0, 0};
        tbl[14] = '{1'b1, 2'd2, B_INC,           1, 59, 2, 0, 3, 0, 0};
        tbl[15] = '{1'b1, 2'd2, B_STATE,         1, 59, 2, 0, 0, 0, 0};
        tbl[16] = '{1'b1, 2'd1, B_NONE,          0,  0, 0, 0, 0, 0, 0};
        tbl[17] = '{1'b1, 2'd2, B_STATE,         1, 59, 2, 0, 1, 0, 0};
        tbl[18] = '{1'b1, 2'd2, B_DEC | B_INC,   1,  0, 2, 0, 1, 0, 0};
        tbl[19] = '{1'b1, 2'd2, B_DEC,           1, 59, 2, 0, 1, 0, 0};
        tbl[20] = '{1'b1, 2'd3, B_NONE,          0,  0, 0, 0, 0, 0, 0};

        reset_n = 1'b0;
        {ia.en, ia.ch_sel, ia.state, ia.start, ia.inc, ia.dec, ia.rld} = '0;
        {ib.en, ib.ch_sel, ib.state, ib.start, ib.inc, ib.dec, ib.rld} = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        chk_disp_a("rst_a", 0, 0, 0, 0, 0, 0, 0);
        chk("rst_a.done", ia.done, 0);
        chk("rst_a.pulse", ia.expire_pulse, 0);
        chk("rst_b.s", ib.seconds, 0);
        chk("rst_b.done", ib.done, 0);

        for (int k = 0; k < 21; k++) begin
            step_a(tbl[k].en, tbl[k].sel, tbl[k].btn);
            chk_disp_a($sformatf("tbl%0d", k), tbl[k].h, tbl[k].m, tbl[k].s, tbl[k].c,
                       tbl[k].md, tbl[k].rn, tbl[k].rl);
        end

        // T1: async reset mid-count, ch0 counting down from 00:00:05.00
        step_a(1, 0, B_STATE); step_a(1, 0, B_STATE);
        repeat (5) step_a(1, 0, B_INC);
        step_a(1, 0, B_STATE);
        step_a(1, 0, B_START);
        repeat (100) @(negedge clk);
        chk_disp_a("t1_pre", 0, 0, 4, 0, 3, 1, 0);
        #2 reset_n = 1'b0;
        #1 chk_disp_a("t1_rst", 0, 0, 0, 0, 0, 0, 0);
        chk("t1_rst.done", ia.done, 0);
        ia.ch_sel = 2;
        #1 chk("t1_rst.ch2h", ia.hours, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // T2: ch1 00:03:00 expires after 18000 ticks
        step_a(1, 1, B_STATE);
        repeat (3) step_a(1, 1, B_INC);
        step_a(1, 1, B_STATE); step_a(1, 1, B_STATE);
        chk_disp_a("t2_set", 0, 3, 0, 0, 3, 0, 0);
        step_a(1, 1, B_START);
        repeat (17999) @(negedge clk);
        chk_disp_a("t2_last", 0, 0, 0, 1, 3, 1, 0);
        chk("t2_last.pulse", ia.expire_pulse[1], 0);
        @(negedge clk);
        chk_disp_a("t2_exp", 0, 0, 0, 0, 3, 2, 0);
        chk("t2_exp.done", ia.done[1], 1);
        chk("t2_exp.pulse", ia.expire_pulse[1], 1);
        chk("t2_exp.any", ia.any_done, 1);
        @(negedge clk);
        chk("t2_post.pulse", ia.expire_pulse[1], 0);
        chk("t2_post.done", ia.done[1], 1);
        step_a(1, 1, B_STATE);
        chk_disp_a("t2_clr", 0, 3, 0, 0, 0, 0, 0);
        chk("t2_clr.done", ia.done[1], 0);

        // T5: start with all-zero value expires on the next cycle
        repeat (3) step_a(1, 2, B_STATE);
        step_a(1, 2, B_START);
        chk("t5.run", ia.run, 2);
        chk("t5.done", ia.done[2], 1);
        chk("t5.pulse", ia.expire_pulse[2], 1);
        @(negedge clk);
        chk("t5.pulse2", ia.expire_pulse[2], 0);

        // T3: ch0 00:00:01 with auto-reload
        step_a(1, 0, B_STATE); step_a(1, 0, B_STATE);
        step_a(1, 0, B_INC);
        step_a(1, 0, B_RLD);
        step_a(1, 0, B_STATE);
        chk_disp_a("t3_set", 0, 0, 1, 0, 3, 0, 1);
        step_a(1, 0, B_START);
        npulse = 0; first_k = 0; last_k = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (ia.expire_pulse[0]) begin
                npulse++;
                if (first_k == 0) first_k = k;
                last_k = k;
            end
            if (k == 50) chk_disp_a("t3_mid", 0, 0, 0, 50, 3, 1, 1);
        end
        chk("t3.npulse", npulse, 3);
        chk("t3.first", first_k, 100);
        chk("t3.last", last_k, 300);
        chk_disp_a("t3_rl", 0, 0, 1, 0, 3, 1, 1);
        c0 = cyc;

        // T4: ch3 00:00:02 running alongside ch0; en=0 buttons ignored
        step_a(1, 3, B_STATE); step_a(1, 3, B_STATE);
        repeat (2) step_a(1, 3, B_INC);
        step_a(1, 3, B_STATE);
        step_a(1, 3, B_START);
        c3 = cyc;
        step_a(0, 3, B_START);
        step_a(0, 0, B_STATE);
        step_a(0, 3, B_RLD);
        repeat (20) @(negedge clk);
        ia.ch_sel = 0;
        #1;
        e = cyc - c0;
        r = 100 - (e % 100);
        chk_disp_a("t4_ch0", 0, 0, (r == 100) ? 1 : 0, (r == 100) ? 0 : r, 3, 1, 1);
        chk("t4.done0", ia.done[0], 1);
        ia.ch_sel = 3;
        #1;
        e = 200 - (cyc - c3);
        chk_disp_a("t4_ch3", 0, 0, e / 100, e % 100, 3, 1, 0);
        @(negedge clk);

        // T6: instance B, tick every 4th cycle; pause on a tick cycle
        step_b(1, 0, B_STATE); step_b(1, 0, B_STATE);
        step_b(1, 0, B_INC);
        step_b(1, 0, B_STATE);
        step_b(1, 0, B_START);
        v = ib.seconds * 100 + ib.centis;
        chk("t6.v0", v, 100);
        ndec = 0; first_k = 0; last_k = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            vn = ib.seconds * 100 + ib.centis;
            if (vn != v) begin
                ndec++;
                chk("t6.step", vn, v - 1);
                if (first_k == 0) first_k = k;
                last_k = k;
                v = vn;
            end
        end
        chk("t6.ndec", ndec, 3);
        chk("t6.span", last_k - first_k, 8);
        repeat (last_k + 3 - 12) @(negedge clk);
        step_b(1, 0, B_START);
        chk("t6.run", ib.run, 0);
        chk("t6.hold", ib.seconds * 100 + ib.centis, v);
        repeat (8) @(negedge clk);
        chk("t6.hold2", ib.seconds * 100 + ib.centis, v);

        // out-of-range ch_sel on 3-channel instance
        step_b(1, 3, B_STATE);
        chk("oor.s", ib.seconds, 0);
        chk("oor.c", ib.centis, 0);
        chk("oor.md", ib.mode, 0);
        ib.ch_sel = 0;
        #1 chk("oor.ch0md", ib.mode, 3);
        chk("oor.ch0c", ib.centis, v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
